// File: rtl/multi_lane_writeback_if.sv
// Bundles the retire-side inputs, regfile write ports, redirect and
// difftest commit handshake of the multi-lane writeback stage.
interface multi_lane_writeback_if #(
  parameter int LANES = 2,
  parameter int XLEN  = 64
);
  logic [LANES-1:0]      in_valid;
  logic [LANES-1:0]      in_is_wb;
  logic [LANES-1:0]      in_is_jump;
  logic [LANES-1:0]      in_br_taken;
  logic [5*LANES-1:0]    in_rd;
  logic [XLEN*LANES-1:0] in_data;
  logic [XLEN*LANES-1:0] in_target;
  logic [XLEN*LANES-1:0] in_pc;
  logic [32*LANES-1:0]   in_instr;
  logic                  in_ready;

  logic [LANES-1:0]      wb_en;
  logic [5*LANES-1:0]    wb_rd;
  logic [XLEN*LANES-1:0] wb_data;

  logic                  redirect_en;
  logic [XLEN-1:0]       redirect_pc;

  logic                  cm_valid;
  logic                  cm_ready;
  logic                  cm_is_wb;
  logic [4:0]            cm_rd;
  logic [XLEN-1:0]       cm_data;
  logic [XLEN-1:0]       cm_pc;
  logic [31:0]           cm_instr;

  modport master (
    output in_valid, in_is_wb, in_is_jump, in_br_taken, in_rd, in_data,
           in_target, in_pc, in_instr, cm_ready,
    input  in_ready, wb_en, wb_rd, wb_data, redirect_en, redirect_pc,
           cm_valid, cm_is_wb, cm_rd, cm_data, cm_pc, cm_instr
  );

  modport slave (
    input  in_valid, in_is_wb, in_is_jump, in_br_taken, in_rd, in_data,
           in_target, in_pc, in_instr, cm_ready,
    output in_ready, wb_en, wb_rd, wb_data, redirect_en, redirect_pc,
           cm_valid, cm_is_wb, cm_rd, cm_data, cm_pc, cm_instr
  );
endinterface

// File: rtl/multi_lane_writeback.sv
// N-lane writeback/commit stage: registered regfile writes, redirect pulse,
// and an in-order compacted commit queue drained one entry per cycle.
module multi_lane_writeback #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 64
) (
  input logic clk,
  input logic rst,
  multi_lane_writeback_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(LANES + 1);

  typedef struct packed {
    logic            isWb;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rdPtr, wrPtr;
  logic [CW-1:0]   count;
  logic            accept, pop;
  logic [LANES-1:0] live, writes, wbNext;
  logic [XLEN-1:0] wdata [LANES];
  logic [PW-1:0]   slotIdx [LANES];
  logic [OW-1:0]   pushCnt;
  logic            redirNext;
  logic [XLEN-1:0] redirPcNext;

  assign bus.in_ready = (DEPTH - 32'(count)) >= LANES;
  assign accept       = bus.in_ready && (|bus.in_valid);
  assign bus.cm_valid = count != '0;
  assign pop          = bus.cm_valid && bus.cm_ready;

  assign bus.cm_is_wb = mem[rdPtr].isWb;
  assign bus.cm_rd    = mem[rdPtr].rd;
  assign bus.cm_data  = mem[rdPtr].data;
  assign bus.cm_pc    = mem[rdPtr].pc;
  assign bus.cm_instr = mem[rdPtr].instr;

  // Walk lanes oldest-first: the first redirecting lane squashes everything younger,
  // and each live lane gets the next compacted queue slot.
  always_comb begin
    logic squash;
    squash      = 1'b0;
    live        = '0;
    writes      = '0;
    wbNext      = '0;
    pushCnt     = '0;
    redirNext   = 1'b0;
    redirPcNext = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      wdata[k]   = bus.in_is_jump[k] ? bus.in_pc[k*XLEN +: XLEN] + XLEN'(4)
                                     : bus.in_data[k*XLEN +: XLEN];
      slotIdx[k] = wrPtr + PW'(pushCnt);
      live[k]    = bus.in_valid[k] && !squash;
      writes[k]  = live[k] && (bus.in_is_wb[k] || bus.in_is_jump[k])
                   && (bus.in_rd[k*5 +: 5] != '0);
      if (live[k]) pushCnt = pushCnt + OW'(1);
      if (live[k] && (bus.in_is_jump[k] || bus.in_br_taken[k])) begin
        squash      = 1'b1;
        redirNext   = 1'b1;
        redirPcNext = bus.in_target[k*XLEN +: XLEN] & ~XLEN'(1);
      end
    end
    // A younger live writer to the same rd wins; only it drives the port.
    for (int unsigned k = 0; k < LANES; k++) begin
      wbNext[k] = writes[k];
      for (int unsigned j = k + 1; j < LANES; j++) begin
        if (writes[j] && (bus.in_rd[j*5 +: 5] == bus.in_rd[k*5 +: 5])) wbNext[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_en       <= '0;
      bus.wb_rd       <= '0;
      bus.wb_data     <= '0;
      bus.redirect_en <= 1'b0;
      bus.redirect_pc <= '0;
      rdPtr           <= '0;
      wrPtr           <= '0;
      count           <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      bus.wb_en       <= accept ? wbNext : '0;
      bus.redirect_en <= accept && redirNext;
      if (accept) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          bus.wb_rd[k*5 +: 5]         <= bus.in_rd[k*5 +: 5];
          bus.wb_data[k*XLEN +: XLEN] <= wdata[k];
          if (live[k]) begin
            mem[slotIdx[k]] <= '{isWb:  bus.in_is_wb[k] || bus.in_is_jump[k],
                                 rd:    bus.in_rd[k*5 +: 5],
                                 data:  wdata[k],
                                 pc:    bus.in_pc[k*XLEN +: XLEN],
                                 instr: bus.in_instr[k*32 +: 32]};
          end
        end
        if (redirNext) bus.redirect_pc <= redirPcNext;
        wrPtr <= wrPtr + PW'(pushCnt);
      end
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + (accept ? CW'(pushCnt) : '0) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_multi_lane_writeback.sv
// Self-checking bench for multi_lane_writeback: queue-based reference model
// compared every cycle, plus directed literal scenarios and random traffic.
module tb_multi_lane_writeback;
  localparam int L = 2;
  localparam int D = 8;
  localparam int X = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_lane_writeback_if #(.LANES(L), .XLEN(X)) bus();
  multi_lane_writeback #(.LANES(L), .DEPTH(D), .XLEN(X)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        isWb;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  int checks = 0;
  int errors = 0;

  ent_t        mq[$];
  logic [L-1:0] expWbEn = '0;
  logic [4:0]  expWbRd [L];
  logic [63:0] expWbData [L];
  logic        expRedir = 1'b0;
  logic [63:0] expRedirPc = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: compare what the DUT shows now, then advance on the inputs it sees this cycle.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      expWbEn  = '0;
      expRedir = 1'b0;
      chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
      chk("rst_wb_data0", bus.wb_data[63:0], 64'd0);
      chk("rst_redirect_en", 64'(bus.redirect_en), 64'd0);
      chk("rst_cm_valid", 64'(bus.cm_valid), 64'd0);
      chk("rst_cm_data", bus.cm_data, 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    end else begin
      int  f;
      int  owner [32];
      bit  acc, pp;
      chk("in_ready", 64'(bus.in_ready), 64'((D - mq.size()) >= L));
      chk("cm_valid", 64'(bus.cm_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("cm_is_wb", 64'(bus.cm_is_wb), 64'(mq[0].isWb));
        chk("cm_rd", 64'(bus.cm_rd), 64'(mq[0].rd));
        chk("cm_data", bus.cm_data, mq[0].data);
        chk("cm_pc", bus.cm_pc, mq[0].pc);
        chk("cm_instr", 64'(bus.cm_instr), 64'(mq[0].instr));
      end
      chk("wb_en", 64'(bus.wb_en), 64'(expWbEn));
      for (int k = 0; k < L; k++) begin
        if (expWbEn[k]) begin
          chk("wb_rd", 64'(bus.wb_rd[k*5 +: 5]), 64'(expWbRd[k]));
          chk("wb_data", bus.wb_data[k*X +: X], expWbData[k]);
        end
      end
      chk("redirect_en", 64'(bus.redirect_en), 64'(expRedir));
      if (expRedir) chk("redirect_pc", bus.redirect_pc, expRedirPc);

      acc = ((D - mq.size()) >= L) && (bus.in_valid != '0);
      pp  = (mq.size() != 0) && bus.cm_ready;
      if (pp) void'(mq.pop_front());
      expWbEn  = '0;
      expRedir = 1'b0;
      if (acc) begin
        f = L;
        for (int k = 0; k < L; k++)
          if (f == L && bus.in_valid[k] && (bus.in_is_jump[k] || bus.in_br_taken[k])) f = k;
        for (int r = 0; r < 32; r++) owner[r] = -1;
        for (int k = 0; k < L; k++) begin
          if (bus.in_valid[k] && k <= f) begin
            ent_t e;
            e.isWb  = bus.in_is_wb[k] || bus.in_is_jump[k];
            e.rd    = bus.in_rd[k*5 +: 5];
            e.data  = bus.in_is_jump[k] ? bus.in_pc[k*X +: X] + 64'd4 : bus.in_data[k*X +: X];
            e.pc    = bus.in_pc[k*X +: X];
            e.instr = bus.in_instr[k*32 +: 32];
            mq.push_back(e);
            expWbRd[k]   = e.rd;
            expWbData[k] = e.data;
            if (e.isWb && e.rd != 5'd0) owner[e.rd] = k;
          end
        end
        for (int r = 1; r < 32; r++) if (owner[r] >= 0) expWbEn[owner[r]] = 1'b1;
        if (f < L) begin
          expRedir   = 1'b1;
          expRedirPc = {bus.in_target[f*X + 1 +: X-1], 1'b0};
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    bus.in_valid    = '0;
    bus.in_is_wb    = '0;
    bus.in_is_jump  = '0;
    bus.in_br_taken = '0;
    bus.in_rd       = '0;
    bus.in_data     = '0;
    bus.in_target   = '0;
    bus.in_pc       = '0;
    bus.in_instr    = '0;
  endtask

  task automatic setLane(input int k, input logic v, input logic wb, input logic jmp,
                         input logic br, input logic [4:0] rd, input logic [63:0] data,
                         input logic [63:0] tgt, input logic [63:0] pc);
    bus.in_valid[k]          = v;
    bus.in_is_wb[k]          = wb;
    bus.in_is_jump[k]        = jmp;
    bus.in_br_taken[k]       = br;
    bus.in_rd[k*5 +: 5]      = rd;
    bus.in_data[k*X +: X]    = data;
    bus.in_target[k*X +: X]  = tgt;
    bus.in_pc[k*X +: X]      = pc;
    bus.in_instr[k*32 +: 32] = pc[31:0] ^ 32'h0000_0013;
  endtask

  initial begin
    clearIn();
    bus.cm_ready = 1'b1;
    #2 rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // Two independent writes, committed in order.
    setLane(0, 1, 1, 0, 0, 5'd3, 64'd5, 64'd0, 64'h100);
    setLane(1, 1, 1, 0, 0, 5'd4, 64'd7, 64'd0, 64'h104);
    step(); clearIn();
    chk("t2_wb_en", 64'(bus.wb_en), 64'h3);
    chk("t2_wb_data1", bus.wb_data[127:64], 64'd7);
    chk("t2_head_rd", 64'(bus.cm_rd), 64'd3);
    chk("t2_head_data", bus.cm_data, 64'd5);
    step();
    chk("t2_second_rd", 64'(bus.cm_rd), 64'd4);
    chk("t2_second_data", bus.cm_data, 64'd7);
    step();

    // JAL on lane 0 squashes lane 1.
    setLane(0, 1, 0, 1, 0, 5'd1, 64'hdead, 64'h2001, 64'h1000);
    setLane(1, 1, 1, 0, 0, 5'd9, 64'h99, 64'd0, 64'h1004);
    step(); clearIn();
    chk("t3_wb_en", 64'(bus.wb_en), 64'h1);
    chk("t3_wb_data0", bus.wb_data[63:0], 64'h1004);
    chk("t3_redirect_en", 64'(bus.redirect_en), 64'd1);
    chk("t3_redirect_pc", bus.redirect_pc, 64'h2000);
    chk("t3_head_rd", 64'(bus.cm_rd), 64'd1);
    step();
    chk("t3_redirect_gone", 64'(bus.redirect_en), 64'd0);
    chk("t3_lane1_dropped", 64'(bus.cm_valid), 64'd0);

    // WAW on x5: only the younger lane writes.
    setLane(0, 1, 1, 0, 0, 5'd5, 64'd1, 64'd0, 64'h200);
    setLane(1, 1, 1, 0, 0, 5'd5, 64'd2, 64'd0, 64'h204);
    step(); clearIn();
    chk("t4_wb_en", 64'(bus.wb_en), 64'h2);
    chk("t4_wb_data1", bus.wb_data[127:64], 64'd2);
    chk("t4_head_data", bus.cm_data, 64'd1);
    step();
    chk("t4_second_data", bus.cm_data, 64'd2);
    step();

    // Write to x0: suppressed on the port, still committed as a writer.
    setLane(0, 1, 1, 0, 0, 5'd0, 64'h55, 64'd0, 64'h300);
    step(); clearIn();
    chk("t5_wb_en", 64'(bus.wb_en), 64'h0);
    chk("t5_cm_is_wb", 64'(bus.cm_is_wb), 64'd1);
    chk("t5_cm_data", bus.cm_data, 64'h55);
    step();

    // Fill to 7 with the consumer stalled; pointers wrap past DEPTH.
    bus.cm_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      setLane(0, 1, 1, 0, 0, 5'(i + 1), 64'h600 + 64'(i), 64'd0, 64'h400 + 64'(4 * i));
      step();
    end
    clearIn();
    chk("t6_full_ready", 64'(bus.in_ready), 64'd0);
    chk("t6_full_head", bus.cm_data, 64'h600);
    setLane(0, 1, 1, 0, 0, 5'd20, 64'hbad0, 64'd0, 64'h500);
    setLane(1, 1, 1, 0, 0, 5'd21, 64'hbad1, 64'd0, 64'h504);
    step(); step(); clearIn();
    chk("t6_ignored_wb_en", 64'(bus.wb_en), 64'h0);
    chk("t6_hold_head", bus.cm_data, 64'h600);
    bus.cm_ready = 1'b1;
    step();
    chk("t6_ready_back", 64'(bus.in_ready), 64'd1);
    chk("t6_next_head", bus.cm_data, 64'h601);
    for (int i = 0; i < 6; i++) step();
    chk("t6_drained", 64'(bus.cm_valid), 64'd0);

    // Reset with five entries queued.
    bus.cm_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      setLane(0, 1, 1, 0, 0, 5'd7, 64'h700 + 64'(i), 64'd0, 64'h800 + 64'(4 * i));
      step();
    end
    clearIn();
    rst = 1'b1;
    #1;
    chk("t1_cm_valid", 64'(bus.cm_valid), 64'd0);
    chk("t1_wb_en", 64'(bus.wb_en), 64'd0);
    chk("t1_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    rst = 1'b0;
    step();
    chk("t1_still_empty", 64'(bus.cm_valid), 64'd0);

    // Random traffic against the model, with one mid-run reset.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < L; k++) begin
        logic jmp;
        jmp = ($urandom_range(0, 9) == 0);
        setLane(k, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, jmp,
                !jmp && ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 7)),
                {$urandom, $urandom}, {$urandom, $urandom}, {32'd0, $urandom} & ~64'd3);
      end
      bus.cm_ready = ($urandom_range(0, 9) < 6);
      rst = (i == 300);
      step();
    end
    rst = 1'b0;
    clearIn();
    bus.cm_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("final_empty", 64'(bus.cm_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
